// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: FIFO-buffered issue stage around the combinational fpu
// with a registered result handshake and a sticky overflow status bit.
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     in_op,
  input  logic                     in_precision,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              fpu_a,
  output logic [31:0]              fpu_b,
  output logic                     fpu_op,
  output logic                     fpu_precision,
  input  logic [31:0]              fpu_result,
  input  logic                     fpu_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_overflow,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic                     ovf_sticky
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             op;
    logic             prec;
    logic [TAG_W-1:0] tag;
  } entry_t;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic             out_overflow_q, out_overflow_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             push, load;
  always_comb begin
    in_ready = !reset && (count_q < (AW+1)'(DEPTH));
    push     = in_valid && in_ready;
    load     = (count_q != '0) && (!out_valid_q || out_ready);
    head     = (count_q != '0) ? mem_q[rd_q] : '0;
    mem_d    = mem_q;
    // half-precision operands are stored with their upper halves cleared
    if (push) mem_d[wr_q] = '{a:   in_precision ? in_a : {16'h0, in_a[15:0]},
                              b:   in_precision ? in_b : {16'h0, in_b[15:0]},
                              op:  in_op,
                              prec: in_precision,
                              tag: in_tag};
    wr_d           = push ? wr_q + AW'(1) : wr_q;
    rd_d           = load ? rd_q + AW'(1) : rd_q;
    count_d        = count_q + (AW+1)'(push) - (AW+1)'(load);
    out_valid_d    = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_result_d   = load ? (head.prec ? fpu_result : {16'h0, fpu_result[15:0]}) : out_result_q;
    out_overflow_d = load ? fpu_overflow : out_overflow_q;
    out_tag_d      = load ? head.tag : out_tag_q;
    ovf_sticky_d   = (load && fpu_overflow) ? 1'b1 : (clr_sticky ? 1'b0 : ovf_sticky_q);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_q           <= '0;
      rd_q           <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_tag_q      <= '0;
      ovf_sticky_q   <= 1'b0;
    end else begin
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_tag_q      <= out_tag_d;
      ovf_sticky_q   <= ovf_sticky_d;
    end
  end
  assign fpu_a         = head.a;
  assign fpu_b         = head.b;
  assign fpu_op        = head.op;
  assign fpu_precision = head.prec;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_overflow  = out_overflow_q;
  assign out_tag       = out_tag_q;
  assign count         = count_q;
  assign ovf_sticky    = ovf_sticky_q;
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: random and directed checks of the issue queue against a
// queue-based reference model, with a stand-in fpu driving the result ports.
module tb_fpu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  logic             clk = 1'b0;
  logic             reset, in_valid, in_op, in_precision, out_ready, clr_sticky;
  logic [31:0]      in_a, in_b, fpu_a, fpu_b, fpu_result, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             in_ready, fpu_op, fpu_precision, fpu_overflow, out_valid, out_overflow, ovf_sticky;
  logic [2:0]       count;
  int               n_tests = 0;
  int               n_fail  = 0;
  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             op;
    logic             prec;
    logic [TAG_W-1:0] tag;
  } req_t;
  req_t             q[$];
  logic             m_valid, m_ovf, m_sticky;
  logic [31:0]      m_res;
  logic [TAG_W-1:0] m_tag;
  always #5 clk = ~clk;
  fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_precision(in_precision), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_precision(fpu_precision),
    .fpu_result(fpu_result), .fpu_overflow(fpu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_tag(out_tag), .count(count),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
  );
  // stand-in fpu: exact values for the directed operands, a scramble otherwise
  function automatic logic [32:0] fpu_ref(logic [31:0] a, logic [31:0] b, logic op, logic prec);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op && prec) return {1'b0, 32'h40400000};
    if (a == 32'h00003C00 && b == 32'h00004000 && op && !prec) return {1'b0, 32'h00004000};
    if (a == 32'h7F000000 && b == 32'h7F000000 && op && prec) return {1'b1, 32'h7F800000};
    return {^(a[7:0] & b[7:0]), (a ^ {b[30:0], 1'b1}) + {30'h0, op, prec}};
  endfunction
  assign {fpu_overflow, fpu_result} = fpu_ref(fpu_a, fpu_b, fpu_op, fpu_precision);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // one clock cycle: drive, check combinational outputs, step the model, check registers
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b, input logic op,
                     input logic prec, input logic [TAG_W-1:0] tag, input logic ordy,
                     input logic clr, input logic rst, output logic acc);
    logic [32:0] r;
    logic        ld, ps;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_precision = prec; in_tag = tag;
    out_ready = ordy; clr_sticky = clr; reset = rst;
    #1;
    ps  = !rst && v && q.size() < DEPTH;
    acc = ps;
    check("in_ready", {31'h0, in_ready}, {31'h0, !rst && q.size() < DEPTH});
    check("count", {29'h0, count}, q.size());
    check("fpu_a", fpu_a, q.size() ? q[0].a : 32'h0);
    check("fpu_b", fpu_b, q.size() ? q[0].b : 32'h0);
    check("fpu_op_prec", {30'h0, fpu_op, fpu_precision}, q.size() ? {30'h0, q[0].op, q[0].prec} : 32'h0);
    if (rst) begin
      q.delete();
      m_valid = 0; m_res = 0; m_ovf = 0; m_tag = 0; m_sticky = 0;
    end else begin
      ld = q.size() > 0 && (!m_valid || ordy);
      if (ld) begin
        r = fpu_ref(q[0].a, q[0].b, q[0].op, q[0].prec);
        m_res = q[0].prec ? r[31:0] : {16'h0, r[15:0]};
        m_ovf = r[32]; m_tag = q[0].tag; m_valid = 1;
        void'(q.pop_front());
      end else if (ordy) m_valid = 0;
      if (ld && r[32]) m_sticky = 1;
      else if (clr) m_sticky = 0;
      if (ps) q.push_back('{a: prec ? a : {16'h0, a[15:0]}, b: prec ? b : {16'h0, b[15:0]},
                            op: op, prec: prec, tag: tag});
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    check("out_result", out_result, m_res);
    check("out_overflow", {31'h0, out_overflow}, {31'h0, m_ovf});
    check("out_tag", {27'h0, out_tag}, {27'h0, m_tag});
    check("ovf_sticky", {31'h0, ovf_sticky}, {31'h0, m_sticky});
  endtask
  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, ordy, 0, 0, acc);
  endtask
  initial begin
    logic             acc;
    logic [TAG_W-1:0] t;
    int               exp_t;
    reset = 1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_precision = 0; in_tag = 0;
    out_ready = 0; clr_sticky = 0;
    repeat (2) @(posedge clk);
    cyc(1, 32'h1, 32'h2, 0, 1, 7, 1, 1, 1, acc);
    // single-precision add, two edges of latency
    cyc(1, 32'h3F800000, 32'h40000000, 0, 1, 3, 1, 0, 0, acc);
    check("add_lat_not_yet", {31'h0, out_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, acc);
    check("add_valid", {31'h0, out_valid}, 32'h1);
    check("add_result", out_result, 32'h40400000);
    check("add_tag", {27'h0, out_tag}, 32'd3);
    check("add_ovf", {31'h0, out_overflow}, 32'h0);
    // half-precision multiply with upper halves masked
    cyc(1, 32'hDEAD3C00, 32'hBEEF4000, 1, 0, 4, 1, 0, 0, acc);
    check("half_fpu_a", fpu_a, 32'h00003C00);
    check("half_fpu_b", fpu_b, 32'h00004000);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, acc);
    check("half_result", out_result, 32'h00004000);
    idle(2, 1);
    // fill under backpressure until the producer is refused
    t = 1;
    for (int i = 0; i < 8; i++) begin
      cyc(1, {27'h0, t}, 32'h5, 0, 1, t, 0, 0, 0, acc);
      if (!acc) break;
      t++;
    end
    check("fill_count", {29'h0, count}, DEPTH);
    check("fill_in_ready", {31'h0, in_ready}, 32'h0);
    check("fill_out_tag", {27'h0, out_tag}, 32'd1);
    exp_t = 2;
    for (int i = 0; i < 5; i++) begin
      cyc(t != 0, {27'h0, t}, 32'h5, 0, 1, t, 1, 0, 0, acc);
      if (acc) t = 0;
      check("drain_order", {27'h0, out_tag}, exp_t);
      exp_t++;
    end
    idle(3, 1);
    // sticky overflow: a set and clear together keep it set, a lone clear drops it
    cyc(1, 32'h7F000000, 32'h7F000000, 1, 1, 10, 1, 0, 0, acc);
    cyc(1, 32'h7F000000, 32'h7F000000, 1, 1, 11, 1, 0, 0, acc);
    check("ovf_out", {31'h0, out_overflow}, 32'h1);
    check("ovf_sticky_set", {31'h0, ovf_sticky}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, acc);
    check("ovf_set_beats_clr", {31'h0, ovf_sticky}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, acc);
    check("ovf_clr", {31'h0, ovf_sticky}, 32'h0);
    idle(2, 1);
    // reset with entries queued and a result held
    cyc(1, 32'h7F000000, 32'h7F000000, 1, 1, 20, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) cyc(1, 32'h100 + i, 32'h7, 0, 1, TAG_W'(21 + i), 0, 0, 0, acc);
    check("pre_rst_count", {29'h0, count}, 32'd3);
    check("pre_rst_sticky", {31'h0, ovf_sticky}, 32'h1);
    cyc(1, 32'h9, 32'h9, 0, 1, 30, 1, 0, 1, acc);
    check("rst_count", {29'h0, count}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_sticky", {31'h0, ovf_sticky}, 32'h0);
    cyc(1, 32'h3F800000, 32'h40000000, 0, 1, 9, 1, 0, 0, acc);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, acc);
    check("post_rst_tag", {27'h0, out_tag}, 32'd9);
    check("post_rst_result", out_result, 32'h40400000);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, acc);
    check("post_rst_drained", {31'h0, out_valid}, 32'h0);
    // randomized traffic against the model
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(3, 0) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom),
          TAG_W'($urandom), $urandom_range(2, 0) != 0, $urandom_range(7, 0) == 0,
          $urandom_range(63, 0) == 0, acc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
